// File: rtl/stopwatch_ctrl_if.sv
// Control bundle between the stopwatch mode controller and its environment:
// raw buttons/switches in, count strobes, clear, blink gate and mode out.
interface stopwatch_ctrl_if;
    logic       btn_pause;
    logic       btn_clear;
    logic       sw_sel;
    logic       sw_adj;
    logic       tick_sec;
    logic       inc_sec;
    logic       inc_min;
    logic       clr;
    logic       blink_on;
    logic [1:0] state;

    modport master (
        output btn_pause, btn_clear, sw_sel, sw_adj,
        input  tick_sec, inc_sec, inc_min, clr, blink_on, state
    );

    modport slave (
        input  btn_pause, btn_clear, sw_sel, sw_adj,
        output tick_sec, inc_sec, inc_min, clr, blink_on, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: input conditioning, IDLE/RUN/PAUSE/ADJUST FSM and
// enable-pulse dividers driving the digit counter and display blink gate.
//
// state  | meaning
// IDLE   | digits held, run divider cleared, waiting for pause press
// RUN    | run divider counting, tick_sec once per second
// PAUSE  | run divider frozen so resume keeps the partial second
// ADJUST | sw_adj held: periodic inc_sec/inc_min, selected pair blinks
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int RUN_HZ    = 1,
    parameter int ADJ_HZ    = 2,
    parameter int BLINK_HZ  = 5,
    parameter int DB_CYCLES = 65536
) (
    input logic            clk,
    input logic            rst,
    stopwatch_ctrl_if.slave ctl
);

    localparam int RUN_DIV   = CLK_HZ / RUN_HZ;
    localparam int ADJ_DIV   = CLK_HZ / ADJ_HZ;
    localparam int BLINK_DIV = CLK_HZ / BLINK_HZ;
    localparam int RUN_W     = $clog2(RUN_DIV);
    localparam int ADJ_W     = $clog2(ADJ_DIV);
    localparam int BLINK_W   = $clog2(BLINK_DIV);
    localparam int DB_W      = $clog2(DB_CYCLES + 1);

    localparam logic [RUN_W-1:0]   RUN_TC   = RUN_W'(RUN_DIV - 1);
    localparam logic [ADJ_W-1:0]   ADJ_TC   = ADJ_W'(ADJ_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_MAX   = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DB_CYCLES - 1);

    generate
        if (RUN_DIV < 2 || ADJ_DIV < 2 || BLINK_DIV < 2) begin : g_bad_div
            $error("stopwatch_ctrl: CLK_HZ divided by a rate must be at least 2");
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("stopwatch_ctrl: DB_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSE  = 2'b10,
        S_ADJUST = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [3:0] sync_a, sync_b;
    logic       pause_s, clear_s, sel_s, adj_s;
    logic [DB_W-1:0] db_pause_q, db_clear_q;
    logic       pause_ev, clear_ev;

    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [ADJ_W-1:0]   adj_cnt_q, adj_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic blink_ph_q, blink_ph_d;
    logic tick_q, tick_d;
    logic inc_sec_q, inc_sec_d;
    logic inc_min_q, inc_min_d;
    logic clr_q, clr_d;
    logic blink_q, blink_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {ctl.sw_adj, ctl.sw_sel, ctl.btn_clear, ctl.btn_pause};
            sync_b <= sync_a;
        end
    end

    assign pause_s = sync_b[0];
    assign clear_s = sync_b[1];
    assign sel_s   = sync_b[2];
    assign adj_s   = sync_b[3];

    // Saturating counters: the event fires once on the DB_CYCLES-1 -> DB_CYCLES step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_pause_q <= '0;
            db_clear_q <= '0;
        end else begin
            if (!pause_s)
                db_pause_q <= '0;
            else if (db_pause_q != DB_MAX)
                db_pause_q <= db_pause_q + DB_W'(1);
            if (!clear_s)
                db_clear_q <= '0;
            else if (db_clear_q != DB_MAX)
                db_clear_q <= db_clear_q + DB_W'(1);
        end
    end

    assign pause_ev = pause_s && (db_pause_q == DB_LAST);
    assign clear_ev = clear_s && (db_clear_q == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            run_cnt_q   <= '0;
            adj_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            tick_q      <= 1'b0;
            inc_sec_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            clr_q       <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            adj_cnt_q   <= adj_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            tick_q      <= tick_d;
            inc_sec_q   <= inc_sec_d;
            inc_min_q   <= inc_min_d;
            clr_q       <= clr_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_ev) begin
            state_d = (state_q == S_ADJUST) ? S_ADJUST : S_IDLE;
        end else if (adj_s && state_q != S_ADJUST) begin
            state_d = S_ADJUST;
        end else if (!adj_s && state_q == S_ADJUST) begin
            state_d = S_PAUSE;
        end else if (pause_ev) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        run_cnt_d   = run_cnt_q;
        adj_cnt_d   = adj_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        tick_d      = 1'b0;
        inc_sec_d   = 1'b0;
        inc_min_d   = 1'b0;
        clr_d       = clear_ev;

        // Clear takes the wrap cycle away from tick_sec, so clr and tick never coincide.
        if (clear_ev || state_q == S_IDLE) begin
            run_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            if (run_cnt_q == RUN_TC) begin
                run_cnt_d = '0;
                tick_d    = 1'b1;
            end else begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
        end

        if (state_q != S_ADJUST) begin
            adj_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else begin
            if (adj_cnt_q == ADJ_TC) begin
                adj_cnt_d = '0;
                inc_sec_d = sel_s;
                inc_min_d = !sel_s;
            end else begin
                adj_cnt_d = adj_cnt_q + ADJ_W'(1);
            end
            if (blink_cnt_q == BLINK_TC) begin
                blink_cnt_d = '0;
                blink_ph_d  = !blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        blink_d = (state_d == S_ADJUST) && blink_ph_d;
    end

    assign ctl.state    = state_q;
    assign ctl.tick_sec = tick_q;
    assign ctl.inc_sec  = inc_sec_q;
    assign ctl.inc_min  = inc_min_q;
    assign ctl.clr      = clr_q;
    assign ctl.blink_on = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at CLK_HZ=20, RUN_HZ=1, ADJ_HZ=2, BLINK_HZ=5, DB_CYCLES=4:
// pulse scoreboard plus state/blink checkpoints.
module tb_stopwatch_ctrl;

    localparam logic [3:0] K_TICK = 4'b0001;
    localparam logic [3:0] K_ISEC = 4'b0010;
    localparam logic [3:0] K_IMIN = 4'b0100;
    localparam logic [3:0] K_CLR  = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } ev_t;

    typedef struct {
        int         off;
        logic       sel;
        logic       adj;
        logic [1:0] st;
        logic       blink;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    ev_t  sb[$];
    step_t tbl[11];

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .CLK_HZ   (20),
        .RUN_HZ   (1),
        .ADJ_HZ   (2),
        .BLINK_HZ (5),
        .DB_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(sw_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cyc %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [3:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    // Every strobe the DUT emits must match the next expected one in time and kind.
    always @(negedge clk) begin
        logic [3:0] kind;
        ev_t e;
        kind = {sw_if.clr, sw_if.inc_min, sw_if.inc_sec, sw_if.tick_sec};
        if (!rst && kind != 4'b0000) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: cyc %0d kind %b expected none", cyc, kind);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.kind != kind) begin
                    n_fail++;
                    $display("FAIL pulse: got cyc %0d kind %b expected cyc %0d kind %b",
                             cyc, kind, e.cyc, e.kind);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p1, e, r, a0, ea;

        tbl[0]  = '{0,  1'b0, 1'b1, 2'd3, 1'b0};
        tbl[1]  = '{1,  1'b0, 1'b1, 2'd3, 1'b0};
        tbl[2]  = '{3,  1'b0, 1'b1, 2'd3, 1'b0};
        tbl[3]  = '{4,  1'b0, 1'b1, 2'd3, 1'b1};
        tbl[4]  = '{7,  1'b0, 1'b1, 2'd3, 1'b1};
        tbl[5]  = '{8,  1'b0, 1'b1, 2'd3, 1'b0};
        tbl[6]  = '{12, 1'b0, 1'b1, 2'd3, 1'b1};
        tbl[7]  = '{24, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[8]  = '{29, 1'b1, 1'b1, 2'd3, 1'b1};
        tbl[9]  = '{33, 1'b1, 1'b0, 2'd3, 1'b0};
        tbl[10] = '{36, 1'b1, 1'b0, 2'd2, 1'b0};

        sw_if.btn_pause = 1'b0;
        sw_if.btn_clear = 1'b0;
        sw_if.sw_sel    = 1'b0;
        sw_if.sw_adj    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(sw_if.state), 32'd0);
        chk("reset_outputs", 32'({sw_if.tick_sec, sw_if.inc_sec, sw_if.inc_min,
                                  sw_if.clr, sw_if.blink_on}), 32'd0);

        // IDLE -> RUN, one transition for a 10-cycle hold
        p1 = cyc;
        sw_if.btn_pause = 1'b1;
        wait_cyc(p1 + 5);
        chk("idle_before_event", 32'(sw_if.state), 32'd0);
        wait_cyc(p1 + 6);
        chk("run_entry", 32'(sw_if.state), 32'd1);
        e = p1 + 6;
        push(e + 20, K_TICK);
        wait_cyc(p1 + 10);
        chk("run_single_transition", 32'(sw_if.state), 32'd1);
        sw_if.btn_pause = 1'b0;

        // pause 27 cycles after entry, resume 50 cycles later
        wait_cyc(e + 21);
        sw_if.btn_pause = 1'b1;
        wait_cyc(e + 26);
        chk("run_before_pause", 32'(sw_if.state), 32'd1);
        wait_cyc(e + 27);
        chk("pause_entry", 32'(sw_if.state), 32'd2);
        sw_if.btn_pause = 1'b0;
        wait_cyc(e + 71);
        sw_if.btn_pause = 1'b1;
        wait_cyc(e + 76);
        chk("pause_held", 32'(sw_if.state), 32'd2);
        wait_cyc(e + 77);
        chk("resume_run", 32'(sw_if.state), 32'd1);
        r = e + 77;
        sw_if.btn_pause = 1'b0;
        push(r + 13, K_TICK);
        push(r + 33, K_TICK);

        // bounce: high 3, low 1, high 3
        wait_cyc(r + 14); sw_if.btn_pause = 1'b1;
        wait_cyc(r + 17); sw_if.btn_pause = 1'b0;
        wait_cyc(r + 18); sw_if.btn_pause = 1'b1;
        wait_cyc(r + 21); sw_if.btn_pause = 1'b0;
        wait_cyc(r + 30);
        chk("bounce_no_event", 32'(sw_if.state), 32'd1);

        // clear and pause in the same cycle while running
        wait_cyc(r + 35);
        sw_if.btn_pause = 1'b1;
        sw_if.btn_clear = 1'b1;
        push(r + 41, K_CLR);
        wait_cyc(r + 40);
        chk("run_before_clear", 32'(sw_if.state), 32'd1);
        wait_cyc(r + 41);
        chk("clear_to_idle", 32'(sw_if.state), 32'd0);
        wait_cyc(r + 43);
        sw_if.btn_pause = 1'b0;
        sw_if.btn_clear = 1'b0;
        wait_cyc(r + 50);
        chk("clear_pause_ignored", 32'(sw_if.state), 32'd0);

        // adjust mode: minutes, then seconds mid-period, then exit
        a0 = cyc;
        sw_if.sw_adj = 1'b1;
        sw_if.sw_sel = 1'b0;
        ea = a0 + 3;
        push(ea + 10, K_IMIN);
        push(ea + 20, K_IMIN);
        push(ea + 30, K_ISEC);
        wait_cyc(ea - 1);
        chk("adj_not_yet", 32'(sw_if.state), 32'd0);
        for (int i = 0; i < 11; i++) begin
            wait_cyc(ea + tbl[i].off);
            chk($sformatf("adj_state_%0d", tbl[i].off), 32'(sw_if.state), 32'(tbl[i].st));
            chk($sformatf("adj_blink_%0d", tbl[i].off), 32'(sw_if.blink_on), 32'(tbl[i].blink));
            sw_if.sw_sel = tbl[i].sel;
            sw_if.sw_adj = tbl[i].adj;
        end

        // back to RUN, then asynchronous reset mid-cycle
        wait_cyc(ea + 37);
        sw_if.btn_pause = 1'b1;
        wait_cyc(ea + 43);
        chk("run_from_pause", 32'(sw_if.state), 32'd1);
        sw_if.btn_pause = 1'b0;
        wait_cyc(ea + 53);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(sw_if.state), 32'd0);
        chk("async_rst_outputs", 32'({sw_if.tick_sec, sw_if.inc_sec, sw_if.inc_min,
                                      sw_if.clr, sw_if.blink_on}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_cyc(cyc + 30);
        chk("idle_after_reset", 32'(sw_if.state), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
